// File: rtl/fence_pkg.sv
// Shared types and sizing for the geofence front-end: coordinate widths,
// cross-product width and the load/sort/output state encoding.
package fence_pkg;

  localparam int unsigned W           = 10;
  localparam int unsigned N           = 6;
  localparam int unsigned DW          = W + 1;
  localparam int unsigned CW          = 2 * W + 3;
  localparam int unsigned SORT_CYCLES = (N - 1) * (N - 2) / 2;
  localparam int unsigned IW          = 3;
  localparam int unsigned SCW         = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SORT = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/fence_sorter_cross_sign.sv
// Sign of the 2-D cross product (b-a) x (c-a); neg_o=1 means c lies clockwise of b
// as seen from anchor a. Full-width signed arithmetic, no truncation.
module cross_sign
  import fence_pkg::*;
(
  input  logic [W-1:0] ax_i,
  input  logic [W-1:0] ay_i,
  input  logic [W-1:0] bx_i,
  input  logic [W-1:0] by_i,
  input  logic [W-1:0] cx_i,
  input  logic [W-1:0] cy_i,
  output logic         neg_o
);

  logic signed [DW-1:0] dxb_s, dyb_s, dxc_s, dyc_s;
  logic signed [CW-1:0] dxb_e_s, dyb_e_s, dxc_e_s, dyc_e_s;
  logic signed [CW-1:0] p1_s, p2_s, c_s;

  // Deltas fit DW bits as two's complement; products are done at CW bits
  always_comb begin
    dxb_s   = {1'b0, bx_i} - {1'b0, ax_i};
    dyb_s   = {1'b0, by_i} - {1'b0, ay_i};
    dxc_s   = {1'b0, cx_i} - {1'b0, ax_i};
    dyc_s   = {1'b0, cy_i} - {1'b0, ay_i};
    dxb_e_s = {{(CW - DW){dxb_s[DW-1]}}, dxb_s};
    dyb_e_s = {{(CW - DW){dyb_s[DW-1]}}, dyb_s};
    dxc_e_s = {{(CW - DW){dxc_s[DW-1]}}, dxc_s};
    dyc_e_s = {{(CW - DW){dyc_s[DW-1]}}, dyc_s};
    p1_s    = dxb_e_s * dyc_e_s;
    p2_s    = dxc_e_s * dyb_e_s;
    c_s     = p1_s - p2_s;
    neg_o   = c_s[CW-1];
  end

endmodule

// File: rtl/fence_sorter.sv
// Geofence front-end: loads object + N vertices, bubble-sorts vertices 1..N-1
// counter-clockwise around vertex 0, then streams object and vertices out.
module fence_sorter
  import fence_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic [2:0]   out_idx,
  output logic         out_last,
  output logic         busy
);

  state_e          state_q;
  logic [IW-1:0]   cnt_q, k_q, lim_q;
  logic [SCW-1:0]  scnt_q;
  logic [W-1:0]    obj_x_q, obj_y_q;
  logic [W-1:0]    fx_q [N];
  logic [W-1:0]    fy_q [N];
  logic            in_ready_q, out_valid_q, out_last_q, busy_q;
  logic [W-1:0]    out_x_q, out_y_q;
  logic [2:0]      out_idx_q;

  logic [IW-1:0]   k1_s, cnt_m1_s;
  logic [2:0]      idx_p1_s;
  logic [W-1:0]    bx_s, by_s, cx_s, cy_s;
  logic            neg_s;

  // Index arithmetic and operand selection for the current compare pair
  always_comb begin
    k1_s     = k_q + IW'(1);
    cnt_m1_s = cnt_q - IW'(1);
    idx_p1_s = out_idx_q + 3'd1;
    bx_s     = fx_q[k_q];
    by_s     = fy_q[k_q];
    cx_s     = fx_q[k1_s];
    cy_s     = fy_q[k1_s];
  end

  cross_sign u_cross (
    .ax_i  (fx_q[0]),
    .ay_i  (fy_q[0]),
    .bx_i  (bx_s),
    .by_i  (by_s),
    .cx_i  (cx_s),
    .cy_i  (cy_s),
    .neg_o (neg_s)
  );

  // Control FSM, point storage and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      k_q         <= IW'(1);
      lim_q       <= IW'(N - 2);
      scnt_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_idx_q   <= 3'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            if (cnt_q == IW'(0)) begin
              obj_x_q <= X;
              obj_y_q <= Y;
            end else begin
              fx_q[cnt_m1_s] <= X;
              fy_q[cnt_m1_s] <= Y;
            end
            if (cnt_q == IW'(N)) begin
              state_q    <= SORT;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              cnt_q      <= '0;
              k_q        <= IW'(1);
              lim_q      <= IW'(N - 2);
              scnt_q     <= SCW'(SORT_CYCLES - 1);
            end else begin
              cnt_q <= cnt_q + IW'(1);
            end
          end else begin
            cnt_q <= cnt_q;
          end
        end
        SORT: begin
          // Strict negative test keeps collinear vertices in load order
          if (neg_s) begin
            fx_q[k_q]  <= cx_s;
            fy_q[k_q]  <= cy_s;
            fx_q[k1_s] <= bx_s;
            fy_q[k1_s] <= by_s;
          end else begin
            k_q <= k_q;
          end
          if (scnt_q == SCW'(0)) begin
            state_q <= OUT;
          end else begin
            scnt_q <= scnt_q - SCW'(1);
            if (k_q == lim_q) begin
              k_q   <= IW'(1);
              lim_q <= lim_q - IW'(1);
            end else begin
              k_q <= k1_s;
            end
          end
        end
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_x_q     <= obj_x_q;
            out_y_q     <= obj_y_q;
            out_idx_q   <= 3'd0;
            out_last_q  <= 1'b0;
          end else if (out_ready) begin
            if (out_last_q) begin
              state_q     <= LOAD;
              out_valid_q <= 1'b0;
              out_x_q     <= '0;
              out_y_q     <= '0;
              out_idx_q   <= 3'd0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              // out_idx k shows f[k-1], so the next point is f[out_idx]
              out_x_q    <= fx_q[out_idx_q];
              out_y_q    <= fy_q[out_idx_q];
              out_idx_q  <= idx_p1_s;
              out_last_q <= (idx_p1_s == 3'(N));
            end
          end else begin
            out_valid_q <= out_valid_q;
          end
        end
        default: begin
          state_q     <= LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: doc/fence_sorter.md
Name: fence_sorter

Overview:
Upstream front-end of the geofence inside-test stage. Collects one object point and N fence vertices from the serial X/Y stream, then sorts vertices 1..N-1 counter-clockwise around vertex 0 using signed cross products. Streams the object point followed by the ordered vertices to the downstream inside-test stage over a valid/ready handshake.

Parameters:
W, 10, coordinate width in bits (unsigned coordinates)
N, 6, fence vertex count (N >= 3)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_valid  input  1  X/Y carry a point this cycle
in_ready  output  1  block accepts a point this cycle
X  input  W  point x coordinate
Y  input  W  point y coordinate
out_valid  output  1  out_x/out_y hold a point
out_ready  input  1  downstream accepts the point
out_x  output  W  output x coordinate
out_y  output  W  output y coordinate
out_idx  output  3  0 = object, k = sorted vertex k-1
out_last  output  1  high with the final vertex (out_idx == N)
busy  output  1  high in SORT and OUT

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on port reset; when reset==0 at a clk edge, the block enters LOAD and clears the load count and sort counters. It drives in_ready=1, out_valid=0, out_x=0, out_y=0, out_idx=0, out_last=0 and busy=0. Point storage is not cleared.
- Reset mid-load, mid-sort or mid-output discards the frame. No partial output follows reset.
- FSM LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - in_ready=1.
  - Each cycle with in_valid=1 stores one point. Accept 0 is the object; accepts 1..N are fence vertices f[0..N-1].
  - After accept N, go to SORT next cycle. in_valid with no pending accept is a no-op.
- SORT:
  - in_ready=0; in_valid is ignored and no point is stored.
  - Bubble sort over f[1..N-1] with shrinking range. Pass p (0..N-3) compares pairs (k,k+1) for k = 1..N-2-p.
  - Exactly one compare per cycle, so (N-1)(N-2)/2 cycles total (10 for N=6). Latency is fixed and independent of data.
- Compare, with dxk=xk-x0, dyk=yk-y0 as (W+1)-bit signed values:
  - c = dxk*dy(k+1) - dx(k+1)*dyk, computed at 2W+3 bits signed with no truncation.
  - c<0: swap f[k] and f[k+1] this cycle. c>=0: no swap. Collinear points keep their load order (stable).
- OUT:
  - If the last accept was at cycle t, SORT occupies t+1..t+10 and out_valid rises at t+11 (N=6). All outputs are registered.
  - Sequence is the object, then f[0..N-1]; out_idx runs 0..N.
  - Advance only on out_valid&&out_ready. out_x/out_y/out_idx stay stable while out_ready=0.
  - out_last=1 only when out_idx==N.
  - The transfer with out_last goes to LOAD next cycle: out_valid=0, in_ready=1.
- Orientation: result is counter-clockwise in the x-right, y-up convention. f[0] is never moved.

Decomposition:
- Package fence_pkg:
  - W, N
  - state enum {LOAD, SORT, OUT}
  - derived widths: DW=W+1, CW=2W+3
  - SORT_CYCLES=(N-1)(N-2)/2
- One sub-module, cross_sign: combinational. Inputs are the anchor and two points; output is the sign of c (neg flag). Reused downstream by the inside test.

Test Plan:
- Hexagon, scrambled order:
  - Stimulus: object (5,5), fence (4,0),(0,6),(8,2),(0,2),(4,8),(8,6).
  - Response: output (5,5),(4,0),(8,2),(8,6),(4,8),(0,6),(0,2).
  - out_last on (0,2); out_valid 11 cycles after the last accept.
- Already sorted input (4,0),(8,2),(8,6),(4,8),(0,6),(0,2) -> output order identical to input; latency still 11.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles at out_idx=3, and toggle out_ready every cycle for the rest of the frame.
  - Response: no point dropped or duplicated; outputs stable while stalled.
- in_valid held high through SORT/OUT with junk values -> ignored; next frame loads cleanly after out_last.
- reset=0 for one cycle during the SORT phase -> out_valid stays 0, in_ready=1 next cycle; a fresh 7-point frame produces the correct sort.
- Max-range coordinates:
  - Stimulus: anchor (1023,0), fence including (0,1023), (1023,1023), (0,0).
  - Response: correct signed cross-product sign, no overflow; order matches the reference model.
